// File: rtl/game_state_ctrl.sv
// game_state_ctrl: master game flow controller.
// Sequences title -> play -> (pause) -> game over, tracks lives, level and
// score, and drives freeze / level-start strobes to the movers.
//
// Optional feature: define GAME_EXTRA_LIFE_EN to award one life each time
// the score crosses a multiple of 1000 (capped at 7 lives).
//
// Ports:
//   clk, resetN      clock, asynchronous active-low reset
//   startOfFrame     one-cycle pulse per video frame
//   spaceKey         level-sensitive space key (synchronous)
//   playerHit        pulse: ball touched player
//   levelCleared     pulse: last ball of level popped
//   ballPopped       pulse: rope popped a ball
//   gameState[1:0]   0 title, 1 playing/pause, 2 game over
//   lives[2:0]       remaining lives
//   level[3:0]       current level, 1-based
//   score[15:0]      saturating binary score
//   freeze           movers hold position (pause / game over)
//   levelStart       one-cycle pulse, movers reload layout
//   playerWon        valid in game over; 1 = all levels cleared
module game_state_ctrl #(
  parameter int unsigned INIT_LIVES   = 3,
  parameter int unsigned MAX_LEVEL    = 8,
  parameter int unsigned PAUSE_FRAMES = 60,
  parameter int unsigned POP_POINTS   = 10
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        spaceKey,
  input  logic        playerHit,
  input  logic        levelCleared,
  input  logic        ballPopped,
  output logic [1:0]  gameState,
  output logic [2:0]  lives,
  output logic [3:0]  level,
  output logic [15:0] score,
  output logic        freeze,
  output logic        levelStart,
  output logic        playerWon
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned SCORE_W = 16;
  localparam int unsigned LIVES_W = 3;
  localparam int unsigned LEVEL_W = 4;

  typedef enum logic [1:0] {
    ST_TITLE = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic                 space_prev_q, space_prev_d;
  logic [CNT_W-1:0]     frame_cnt_q, frame_cnt_d;
  logic [LIVES_W-1:0]   lives_q, lives_d;
  logic [LEVEL_W-1:0]   level_q, level_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic                 won_q, won_d;
  logic                 level_start_q, level_start_d;
  logic                 freeze_q, freeze_d;
  logic [1:0]           game_state_q, game_state_d;

  logic                 space_press_c;
  logic [SCORE_W:0]     score_sum_c;
  logic [SCORE_W-1:0]   score_pop_c;
  logic [LIVES_W-1:0]   lives_inc_c;
  logic                 award_c;

  // Press = rising edge of the key; prev sample resets high so a key held
  // through reset is not a press.
  assign space_press_c = spaceKey & ~space_prev_q;

  // Saturating score after one pop.
  assign score_sum_c = {1'b0, score_q} + (SCORE_W+1)'(POP_POINTS);
  assign score_pop_c = score_sum_c[SCORE_W] ? {SCORE_W{1'b1}} : score_sum_c[SCORE_W-1:0];

  assign lives_inc_c = (lives_q == 3'd7) ? 3'd7 : lives_q + 3'd1;

`ifdef GAME_EXTRA_LIFE_EN
  logic [SCORE_W-1:0] thr_q, thr_d;

  // Next 1000-point threshold; parks at all-ones once past the last multiple.
  always_comb begin
    thr_d   = thr_q;
    award_c = 1'b0;
    if (state_q == ST_TITLE && space_press_c) begin
      thr_d = 16'd1000;
    end else if (state_q == ST_PLAY && ballPopped && thr_q != 16'hFFFF &&
                 score_pop_c >= thr_q) begin
      award_c = 1'b1;
      thr_d   = (thr_q > 16'(65535 - 1000)) ? 16'hFFFF : thr_q + 16'd1000;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) thr_q <= 16'd1000;
    else         thr_q <= thr_d;
  end
`else
  assign award_c = 1'b0;
`endif

  // Next-state and output computation.
  always_comb begin
    state_d       = state_q;
    space_prev_d  = spaceKey;
    frame_cnt_d   = frame_cnt_q;
    lives_d       = lives_q;
    level_d       = level_q;
    score_d       = score_q;
    won_d         = won_q;
    level_start_d = 1'b0;

    unique case (state_q)
      ST_TITLE: begin
        if (space_press_c) begin
          state_d       = ST_PLAY;
          lives_d       = LIVES_W'(INIT_LIVES);
          level_d       = 4'd1;
          score_d       = '0;
          won_d         = 1'b0;
          level_start_d = 1'b1;
        end
      end

      ST_PLAY: begin
        if (ballPopped) score_d = score_pop_c;
        if (award_c) lives_d = lives_inc_c;
        if (playerHit && lives_q == 3'd1) begin
          state_d     = ST_OVER;
          lives_d     = '0;
          won_d       = 1'b0;
          frame_cnt_d = '0;
        end else if (playerHit) begin
          // Award and loss cancel out in the same cycle.
          state_d     = ST_PAUSE;
          lives_d     = award_c ? lives_q : lives_q - 3'd1;
          frame_cnt_d = '0;
        end else if (levelCleared && level_q == LEVEL_W'(MAX_LEVEL)) begin
          state_d     = ST_OVER;
          won_d       = 1'b1;
          frame_cnt_d = '0;
        end else if (levelCleared) begin
          state_d     = ST_PAUSE;
          level_d     = level_q + 4'd1;
          frame_cnt_d = '0;
        end
      end

      ST_PAUSE: begin
        if (startOfFrame) begin
          if (frame_cnt_q == CNT_W'(PAUSE_FRAMES - 1)) begin
            state_d       = ST_PLAY;
            frame_cnt_d   = '0;
            level_start_d = 1'b1;
          end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
      end

      ST_OVER: begin
        // Counter saturates at PAUSE_FRAMES; space only honoured after that.
        if (frame_cnt_q == CNT_W'(PAUSE_FRAMES) && space_press_c) begin
          state_d = ST_TITLE;
        end else if (startOfFrame && frame_cnt_q != CNT_W'(PAUSE_FRAMES)) begin
          frame_cnt_d = frame_cnt_q + 8'd1;
        end
      end

      default: state_d = ST_TITLE;
    endcase

    freeze_d = (state_d == ST_PAUSE) || (state_d == ST_OVER);

    unique case (state_d)
      ST_TITLE: game_state_d = 2'd0;
      ST_OVER:  game_state_d = 2'd2;
      default:  game_state_d = 2'd1;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= ST_TITLE;
      space_prev_q  <= 1'b1;
      frame_cnt_q   <= '0;
      lives_q       <= '0;
      level_q       <= '0;
      score_q       <= '0;
      won_q         <= 1'b0;
      level_start_q <= 1'b0;
      freeze_q      <= 1'b0;
      game_state_q  <= 2'd0;
    end else begin
      state_q       <= state_d;
      space_prev_q  <= space_prev_d;
      frame_cnt_q   <= frame_cnt_d;
      lives_q       <= lives_d;
      level_q       <= level_d;
      score_q       <= score_d;
      won_q         <= won_d;
      level_start_q <= level_start_d;
      freeze_q      <= freeze_d;
      game_state_q  <= game_state_d;
    end
  end

  assign gameState  = game_state_q;
  assign lives      = lives_q;
  assign level      = level_q;
  assign score      = score_q;
  assign freeze     = freeze_q;
  assign levelStart = level_start_q;
  assign playerWon  = won_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Self-checking bench for game_state_ctrl: directed game scenarios plus a
// randomized phase, all compared against a rule-level reference model.
module tb_game_state_ctrl;

  localparam int INIT_LIVES = 3;
  localparam int MAX_LEVEL  = 8;
  localparam int PF         = 60;
  localparam int POP        = 10;

  localparam int M_TITLE = 0;
  localparam int M_PLAY  = 1;
  localparam int M_PAUSE = 2;
  localparam int M_OVER  = 3;

  logic        clk = 1'b0;
  logic        resetN;
  logic        startOfFrame, spaceKey, playerHit, levelCleared, ballPopped;
  logic [1:0]  gameState;
  logic [2:0]  lives;
  logic [3:0]  level;
  logic [15:0] score;
  logic        freeze, levelStart, playerWon;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_st, m_lives, m_level, m_score, m_won, m_frames, m_thr, m_lstart;
  bit m_prev;

  game_state_ctrl dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .spaceKey(spaceKey),
    .playerHit(playerHit), .levelCleared(levelCleared), .ballPopped(ballPopped),
    .gameState(gameState), .lives(lives), .level(level), .score(score),
    .freeze(freeze), .levelStart(levelStart), .playerWon(playerWon)
  );

  always #5 clk = ~clk;

  function automatic int cap7(input int v);
    return (v > 7) ? 7 : v;
  endfunction

  task automatic model_reset();
    m_st = M_TITLE; m_lives = 0; m_level = 0; m_score = 0; m_won = 0;
    m_frames = 0; m_thr = 1000; m_lstart = 0; m_prev = 1'b1;
  endtask

  task automatic model_step(input bit sof, input bit sp, input bit hit,
                            input bit clr, input bit pop);
    bit press;
    int sc;
    int extra;
    press    = sp && !m_prev;
    m_prev   = sp;
    m_lstart = 0;
    case (m_st)
      M_TITLE: if (press) begin
        m_st = M_PLAY; m_lives = INIT_LIVES; m_level = 1; m_score = 0;
        m_won = 0; m_lstart = 1; m_thr = 1000;
      end
      M_PLAY: begin
        sc = m_score + (pop ? POP : 0);
        if (sc > 65535) sc = 65535;
        extra = 0;
`ifdef GAME_EXTRA_LIFE_EN
        if (pop && sc >= m_thr) begin extra = 1; m_thr += 1000; end
`endif
        m_score = sc;
        if (hit && m_lives == 1) begin
          m_st = M_OVER; m_lives = 0; m_won = 0; m_frames = 0;
        end else if (hit) begin
          m_st = M_PAUSE; m_lives = cap7(m_lives - 1 + extra); m_frames = 0;
        end else if (clr && m_level == MAX_LEVEL) begin
          m_st = M_OVER; m_won = 1; m_lives = cap7(m_lives + extra); m_frames = 0;
        end else if (clr) begin
          m_st = M_PAUSE; m_level++; m_lives = cap7(m_lives + extra); m_frames = 0;
        end else begin
          m_lives = cap7(m_lives + extra);
        end
      end
      M_PAUSE: if (sof) begin
        m_frames++;
        if (m_frames == PF) begin m_st = M_PLAY; m_lstart = 1; m_frames = 0; end
      end
      default: begin
        if (m_frames >= PF && press) m_st = M_TITLE;
        else if (sof && m_frames < PF) m_frames++;
      end
    endcase
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int gs;
    gs = (m_st == M_TITLE) ? 0 : (m_st == M_OVER) ? 2 : 1;
    chk({tag, ".gameState"},  int'(gameState),  gs);
    chk({tag, ".lives"},      int'(lives),      m_lives);
    chk({tag, ".level"},      int'(level),      m_level);
    chk({tag, ".score"},      int'(score),      m_score);
    chk({tag, ".freeze"},     int'(freeze),     (m_st == M_PAUSE || m_st == M_OVER) ? 1 : 0);
    chk({tag, ".levelStart"}, int'(levelStart), m_lstart);
    chk({tag, ".playerWon"},  int'(playerWon),  m_won);
  endtask

  // Apply inputs between edges, advance one clock, check #1 after the edge.
  task automatic step(input string tag, input bit sof, input bit sp,
                      input bit hit, input bit clr, input bit pop);
    startOfFrame = sof; spaceKey = sp; playerHit = hit;
    levelCleared = clr; ballPopped = pop;
    @(posedge clk);
    model_step(sof, sp, hit, clr, pop);
    #1;
    check_all(tag);
  endtask

  task automatic run_to_play(input string tag, input int limit);
    for (int i = 0; i < limit && m_st != M_PLAY; i++)
      step(tag, $urandom_range(0, 2) == 0, 1'b0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    chk({tag, ".timeout_freeze"}, int'(freeze), 0);
  endtask

  task automatic run_over_to_title(input string tag, input int limit);
    bit sp;
    sp = 1'b0;
    for (int i = 0; i < limit && m_st != M_TITLE; i++) begin
      if ($urandom_range(0, 3) == 0) sp = ~sp;
      step(tag, $urandom_range(0, 1) == 1, sp, 1'b0, 1'b0, 1'b0);
    end
    chk({tag, ".timeout_gs"}, int'(gameState), 0);
  endtask

  task automatic start_game(input string tag);
    step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(tag, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk({tag, ".start_gs"}, int'(gameState), 1);
    chk({tag, ".start_ls"}, int'(levelStart), 1);
    step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bit sp;
    resetN = 1'b0; spaceKey = 1'b1; startOfFrame = 1'b0;
    playerHit = 1'b0; levelCleared = 1'b0; ballPopped = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    resetN = 1'b1;

    // Key held through reset release is not a press.
    for (int i = 0; i < 3; i++) step("held_space", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("held_space_gs", int'(gameState), 0);

    // Release then press starts the game.
    step("release", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("press", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("start_gs", int'(gameState), 1);
    chk("start_lives", int'(lives), 3);
    chk("start_level", int'(level), 1);
    chk("start_ls", int'(levelStart), 1);
    step("after_start", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ls_one_cycle", int'(levelStart), 0);

    // Three pops with random gaps.
    for (int i = 0; i < 3; i++) begin
      step("pop", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      repeat ($urandom_range(0, 3)) step("pop_gap", $urandom_range(0, 1) == 1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk("score30", int'(score), 30);

    // Non-final hit, pause, retry of the same level.
    step("hit", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("hit_lives", int'(lives), 2);
    chk("hit_freeze", int'(freeze), 1);
    chk("hit_gs", int'(gameState), 1);
    run_to_play("pause1", 2000);
    chk("retry_level", int'(level), 1);

    // Drive score up to saturation.
    for (int i = 0; i < 6550; i++) step("bulk_pop", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("score65530", int'(score), 65530);
    step("sat_pop", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("score_sat", int'(score), 65535);
    step("sat_pop2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("score_sat2", int'(score), 65535);

    // Burn lives down to one, then simultaneous hit + clear ends the game.
    for (int i = 0; i < 8 && m_lives > 1; i++) begin
      step("burn_hit", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      run_to_play("burn_pause", 2000);
    end
    step("final_hit", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("over_gs", int'(gameState), 2);
    chk("over_lives", int'(lives), 0);
    chk("over_won", int'(playerWon), 0);

    // Space presses inside the hold-off window are ignored.
    sp = 1'b0;
    for (int i = 0; i < 40; i++) begin
      sp = ~sp;
      step("over_window", i[0], sp, 1'b0, 1'b0, 1'b0);
    end
    chk("window_gs", int'(gameState), 2);
    run_over_to_title("over_exit", 3000);
    chk("title_lives_hold", int'(lives), 0);

    // Clear every level to win.
    start_game("game2");
    for (int lv = 1; lv <= MAX_LEVEL; lv++) begin
      step("clear", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      if (lv < MAX_LEVEL) run_to_play("clear_pause", 2000);
    end
    chk("won_gs", int'(gameState), 2);
    chk("won_flag", int'(playerWon), 1);
    chk("won_level", int'(level), MAX_LEVEL);

    // Asynchronous reset in the middle of a pause.
    run_over_to_title("won_exit", 3000);
    chk("title_won_hold", int'(playerWon), 1);
    start_game("game3");
    step("hit3", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step("pause3", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #3;
    resetN = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    @(posedge clk); #1;
    check_all("in_reset");
    resetN = 1'b1;
    step("post_reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("no_strobe_release", int'(levelStart), 0);

    // Randomized play against the model.
    sp = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 5) == 0) sp = ~sp;
      step("random", $urandom_range(0, 3) == 0, sp, $urandom_range(0, 39) == 0,
           $urandom_range(0, 29) == 0, $urandom_range(0, 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
